exe_operand_forward: RTL
========================

# exe_operand_forward

Operand-delivery stage between decode and execute. Consumes the per-operand select codes produced by the forwarding unit and keeps a two-deep history of results from instructions that have left EXE. Presents registered, already-forwarded operands A/B to the EXE stage. Detects load-use hazards, freezes ID while load data is outstanding, and inserts a bubble into EXE.

## Interface
Parameters:
- WIDTH, 32, operand/result data width

Ports:
- CLK  in  1  pipeline clock, rising edge
- RESET  in  1  asynchronous, active-low reset
- ID_Valid  in  1  ID holds a real instruction
- A_Select  in  2  forwarding code for operand A: 0 reg file, 1 EXE, 2 MEM, 3 WB
- B_Select  in  2  same for operand B
- RegA_In, RegB_In  in  WIDTH  register-file read data, write-through from WB
- EXE_Result  in  WIDTH  ALU result of the instruction currently in EXE
- EXE_Valid  in  1  EXE holds a real instruction
- EXE_Is_Load  in  1  EXE instruction is a load; its EXE_Result is an address, not data
- MEM_Load_Data  in  WIDTH  load data for the instruction in MEM
- MEM_Load_Valid  in  1  MEM_Load_Data valid this cycle
- Stall_In  in  1  branch/JR stall from the forwarding unit
- Op_A, Op_B  out  WIDTH  registered forwarded operands to EXE
- Op_Valid  out  1  registered; 0 = bubble into EXE
- Stall_Out  out  1  combinational; hold PC and ID this cycle

## Operation
- History slots S1 (instruction now in MEM) and S2 (now in WB). Each slot holds value, valid, and pending. Pending means the slot is a load whose data has not arrived.
- Every clock: S2 <= S1. S1 <= {EXE_Result, valid=EXE_Valid, pending=EXE_Valid&EXE_Is_Load}.
- If S1 is pending and MEM_Load_Valid is 1: the value shifting into S2 is MEM_Load_Data and pending clears. Otherwise a pending S1 shifts into S2 still pending. A pending S2 that is never filled is a pipeline error and triggers no action here.
- Operand source per code: 0 RegX_In, 1 EXE_Result, 2 S1.value, 3 S2.value.
- If the selected slot is invalid, the block uses RegX_In.
- FSM states:
  - RUN
    - Stall_In=1: Op_Valid<=0. Stall_Out is 0 because the forwarding unit already holds ID. Stay in RUN.
    - Otherwise, hazard = ID_Valid & EXE_Valid & EXE_Is_Load & (A_Select==1 | B_Select==1).
    - Hazard: Stall_Out=1, Op_Valid<=0, capture A_Select/B_Select into Held_A/Held_B, go to LOAD_WAIT.
    - No hazard: Op_A/Op_B <= selected sources, Op_Valid<=ID_Valid.
  - LOAD_WAIT
    - Selects come from Held_*, aged one step: 1 -> MEM_Load_Data, 2 -> S2.value, 3 -> RegX_In.
    - MEM_Load_Valid=1: latch operands, Op_Valid<=1, Stall_Out=0, go to RUN.
    - MEM_Load_Valid=0: Stall_Out=1, Op_Valid<=0. Held selects are not aged again. Stay in LOAD_WAIT.
- Stall_In is ignored in LOAD_WAIT.

## Timing
- Operand latency: 1 cycle, from the selects being sampled to Op_A/Op_B at the EXE input.
- Stall_Out is a same-cycle combinational function of state and inputs.
- Minimum load-use penalty: exactly 1 bubble.
- Reset, asynchronous and taking effect immediately, including mid-LOAD_WAIT:
  - state = RUN
  - Op_A = Op_B = 0, Op_Valid = 0
  - S1/S2 value = 0, valid = 0, pending = 0
  - Held_A = Held_B = 0
  - Stall_Out = 0 after reset, since state is RUN and EXE_Valid is expected to be low
- Both operands hitting the load: a single hazard and a single bubble.
- Code 1 with EXE_Valid=0: treated as code 0.

## Structure
- Shared pipeline package holds:
  - select constants SEL_REG=0, SEL_EXE=1, SEL_MEM=2, SEL_WB=3
  - FSM state encoding RUN/LOAD_WAIT
  - WIDTH default
- One sub-module, fwd_result_slot, instantiated twice: a value/valid/pending register with shift-in and load-fill ports.

## Test plan
- Reset mid-LOAD_WAIT -> all outputs 0 immediately and state RUN. The next non-hazard ID instruction issues normally.
- RUN, A_Select=1, EXE_Result=0x0000_0010, not a load -> next cycle Op_A=0x10, Op_Valid=1, Stall_Out never asserted.
- A_Select=2, S1 holds 0xDEAD_BEEF; B_Select=3, S2 holds 0x1234 -> Op_A=0xDEADBEEF, Op_B=0x1234.
- Load in EXE, A_Select=1 -> Stall_Out=1 one cycle, Op_Valid=0. Then MEM_Load_Valid with data 0xCAFE -> Op_A=0xCAFE, Op_Valid=1, state RUN.
- Load-use with MEM_Load_Valid delayed 3 cycles -> Stall_Out held 3 cycles, 3 bubbles. Operand equals the late data, not EXE_Result.
- Stall_In=1 with a simultaneous load-use condition -> Stall_Out=0, Op_Valid=0, state stays RUN, history still shifts.

Source files
------------

// File: rtl/exe_operand_forward_pkg.sv
// Shared pipeline definitions for operand forwarding.
// Select codes, FSM encoding and default width.
package exe_operand_forward_pkg;

  localparam int WIDTH_DEF = 32;

  localparam logic [1:0] SEL_REG = 2'd0;
  localparam logic [1:0] SEL_EXE = 2'd1;
  localparam logic [1:0] SEL_MEM = 2'd2;
  localparam logic [1:0] SEL_WB  = 2'd3;

  typedef enum logic {
    RUN       = 1'b0,
    LOAD_WAIT = 1'b1
  } fwd_state_e;

endpackage

// File: rtl/fwd_result_slot.sv
// One history slot: value, valid and load-pending flag.
// Shifts in every clock; a pending entry can be filled on the way in.
import exe_operand_forward_pkg::*;

module fwd_result_slot #(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [WIDTH-1:0] in_value,
  input  logic             in_valid,
  input  logic             in_pending,
  input  logic             fill_en,
  input  logic [WIDTH-1:0] fill_value,
  output logic [WIDTH-1:0] value,
  output logic             valid,
  output logic             pending
);

  // Shift the incoming entry in, replacing a pending value with fill data.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      value   <= '0;
      valid   <= 1'b0;
      pending <= 1'b0;
    end else begin
      valid <= in_valid;
      if (fill_en && in_pending) begin
        value   <= fill_value;
        pending <= 1'b0;
      end else begin
        value   <= in_value;
        pending <= in_pending;
      end
    end
  end

endmodule

// File: rtl/exe_operand_forward.sv
// Operand delivery into EXE with result history,
// load-use detection and ID freeze.
import exe_operand_forward_pkg::*;

module exe_operand_forward #(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             ID_Valid,
  input  logic [1:0]       A_Select,
  input  logic [1:0]       B_Select,
  input  logic [WIDTH-1:0] RegA_In,
  input  logic [WIDTH-1:0] RegB_In,
  input  logic [WIDTH-1:0] EXE_Result,
  input  logic             EXE_Valid,
  input  logic             EXE_Is_Load,
  input  logic [WIDTH-1:0] MEM_Load_Data,
  input  logic             MEM_Load_Valid,
  input  logic             Stall_In,
  output logic [WIDTH-1:0] Op_A,
  output logic [WIDTH-1:0] Op_B,
  output logic             Op_Valid,
  output logic             Stall_Out
);

  fwd_state_e state_q, state_d;

  logic [WIDTH-1:0] s1_value, s2_value;
  logic             s1_valid, s2_valid;
  logic             s1_pending, s2_pending;

  logic [1:0]       held_a, held_b;
  logic             held_en;
  logic             op_en;
  logic             op_valid_d;
  logic             hazard;
  logic [WIDTH-1:0] a_d, b_d;

  fwd_result_slot #(.WIDTH(WIDTH)) u_s1 (
    .CLK       (CLK),
    .RESET     (RESET),
    .in_value  (EXE_Result),
    .in_valid  (EXE_Valid),
    .in_pending(EXE_Valid & EXE_Is_Load),
    .fill_en   (1'b0),
    .fill_value({WIDTH{1'b0}}),
    .value     (s1_value),
    .valid     (s1_valid),
    .pending   (s1_pending)
  );

  fwd_result_slot #(.WIDTH(WIDTH)) u_s2 (
    .CLK       (CLK),
    .RESET     (RESET),
    .in_value  (s1_value),
    .in_valid  (s1_valid),
    .in_pending(s1_pending),
    .fill_en   (MEM_Load_Valid),
    .fill_value(MEM_Load_Data),
    .value     (s2_value),
    .valid     (s2_valid),
    .pending   (s2_pending)
  );

  // Normal forwarding mux; an invalid source falls back to the reg file.
  function automatic logic [WIDTH-1:0] pick_run(
    input logic [1:0]       sel,
    input logic [WIDTH-1:0] reg_v,
    input logic [WIDTH-1:0] exe_v,
    input logic             exe_ok,
    input logic [WIDTH-1:0] s1_v,
    input logic             s1_ok,
    input logic [WIDTH-1:0] s2_v,
    input logic             s2_ok
  );
    logic [WIDTH-1:0] r;
    r = reg_v;
    unique case (sel)
      SEL_EXE: if (exe_ok) r = exe_v;
      SEL_MEM: if (s1_ok) r = s1_v;
      SEL_WB:  if (s2_ok) r = s2_v;
      default: r = reg_v;
    endcase
    return r;
  endfunction

  // Held selects aged one stage: the load now sits in MEM.
  function automatic logic [WIDTH-1:0] pick_wait(
    input logic [1:0]       sel,
    input logic [WIDTH-1:0] reg_v,
    input logic [WIDTH-1:0] ld_v,
    input logic [WIDTH-1:0] s2_v,
    input logic             s2_ok
  );
    logic [WIDTH-1:0] r;
    r = reg_v;
    unique case (sel)
      SEL_EXE: r = ld_v;
      SEL_MEM: if (s2_ok) r = s2_v;
      default: r = reg_v;
    endcase
    return r;
  endfunction

  assign hazard = ID_Valid & EXE_Valid & EXE_Is_Load
                & ((A_Select == SEL_EXE) | (B_Select == SEL_EXE));

  // Next state, stall and operand-load decisions.
  always_comb begin
    state_d    = state_q;
    Stall_Out  = 1'b0;
    op_en      = 1'b0;
    op_valid_d = 1'b0;
    held_en    = 1'b0;
    a_d = pick_run(A_Select, RegA_In, EXE_Result, EXE_Valid,
                   s1_value, s1_valid, s2_value, s2_valid);
    b_d = pick_run(B_Select, RegB_In, EXE_Result, EXE_Valid,
                   s1_value, s1_valid, s2_value, s2_valid);
    unique case (1'b1)
      (state_q == RUN): begin
        if (Stall_In) begin
          op_valid_d = 1'b0;
        end else if (hazard) begin
          Stall_Out = 1'b1;
          held_en   = 1'b1;
          state_d   = LOAD_WAIT;
        end else begin
          op_en      = 1'b1;
          op_valid_d = ID_Valid;
        end
      end
      (state_q == LOAD_WAIT): begin
        a_d = pick_wait(held_a, RegA_In, MEM_Load_Data,
                        s2_value, s2_valid);
        b_d = pick_wait(held_b, RegB_In, MEM_Load_Data,
                        s2_value, s2_valid);
        if (MEM_Load_Valid) begin
          op_en      = 1'b1;
          op_valid_d = 1'b1;
          state_d    = RUN;
        end else begin
          Stall_Out = 1'b1;
        end
      end
      default: state_d = RUN;
    endcase
  end

  // State, held selects and registered operands.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q  <= RUN;
      held_a   <= 2'd0;
      held_b   <= 2'd0;
      Op_A     <= '0;
      Op_B     <= '0;
      Op_Valid <= 1'b0;
    end else begin
      state_q  <= state_d;
      Op_Valid <= op_valid_d;
      if (held_en) begin
        held_a <= A_Select;
        held_b <= B_Select;
      end
      if (op_en) begin
        Op_A <= a_d;
        Op_B <= b_d;
      end
    end
  end

endmodule
